rr_arb_param: RTL

RR_ARB_PARAM -- requirements
Module: rr_arb_param

---
 rtl/rr_arb_pkg.sv | 25 ++
 rtl/rr_prio_pick.sv | 33 +++
 rtl/rr_arb_param.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, mode encoding and the one-hot-to-index helper
// for the round-robin arbiter.
package rr_arb_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    MODE_FREEZE,
    MODE_HOLD,
    MODE_PICK,
    MODE_IDLE
  } arb_mode_e;

  // OR-reduction encoder: exact for one-hot input, 0 for all-zero input.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating priority encoder: first set bit of req searched
// from ptr upward, wrapping modulo N.
module rr_prio_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_cand [N];

  // Slot gi of the rotated view holds requestor (ptr + gi) mod N.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign w_cand[gi] = IDW'((32'(ptr) + 32'(gi)) % 32'(N));
      assign w_rot[gi]  = req[w_cand[gi]];
    end
  endgenerate

  // Scan downward so the lowest rotated slot is the last (winning) write.
  always_comb begin
    found = |w_rot;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) idx = w_cand[k];
    end
  end

endmodule

// File: rtl/rr_arb_param.sv
// Round-robin arbiter with bounded hold: registered one-hot grant,
// rotating priority pointer and per-owner hold counter.
module rr_arb_param
  import rr_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] IDX_LAST  = IDW'(N - 1);

  logic [N-1:0]   r_gnt,       w_gnt_next;
  logic           r_gnt_valid, w_gnt_valid_next;
  logic [IDW-1:0] r_gnt_id,    w_gnt_id_next;
  logic [IDW-1:0] r_ptr,       w_ptr_next;
  logic [IDW-1:0] r_owner,     w_owner_next;
  logic           r_own_v,     w_own_v_next;
  logic [HCW-1:0] r_hcnt,      w_hcnt_next;

  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic [N-1:0]   w_pick_oh;
  logic [IDW-1:0] w_pick_id;
  logic [IDW-1:0] w_pick_ptr;
  arb_mode_e      w_mode;

  rr_prio_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_pick_oh  = N'(1) << w_idx;
  assign w_pick_id  = IDW'(onehot_to_idx(32'(w_pick_oh)));
  assign w_pick_ptr = (w_idx == IDX_LAST) ? '0 : w_idx + IDW'(1);

  // With MAX_HOLD = 1, HOLD_LAST is 0 and HOLD can never be selected.
  always_comb begin
    w_mode = MODE_IDLE;
    if (!en)
      w_mode = MODE_FREEZE;
    else if (r_own_v && req[r_owner] && (r_hcnt < HOLD_LAST))
      w_mode = MODE_HOLD;
    else if (w_found)
      w_mode = MODE_PICK;
  end

  always_comb begin
    w_gnt_next       = r_gnt;
    w_gnt_valid_next = r_gnt_valid;
    w_gnt_id_next    = r_gnt_id;
    w_ptr_next       = r_ptr;
    w_owner_next     = r_owner;
    w_own_v_next     = r_own_v;
    w_hcnt_next      = r_hcnt;
    case (w_mode)
      MODE_HOLD: begin
        w_hcnt_next = r_hcnt + HCW'(1);
      end
      MODE_PICK: begin
        w_gnt_next       = w_pick_oh;
        w_gnt_valid_next = 1'b1;
        w_gnt_id_next    = w_pick_id;
        w_owner_next     = w_idx;
        w_own_v_next     = 1'b1;
        w_hcnt_next      = '0;
        w_ptr_next       = w_pick_ptr;
      end
      MODE_IDLE: begin
        w_gnt_next       = '0;
        w_gnt_valid_next = 1'b0;
        w_gnt_id_next    = '0;
        w_owner_next     = '0;
        w_own_v_next     = 1'b0;
        w_hcnt_next      = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_own_v     <= 1'b0;
      r_hcnt      <= '0;
    end else begin
      r_gnt       <= w_gnt_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_gnt_id    <= w_gnt_id_next;
      r_ptr       <= w_ptr_next;
      r_owner     <= w_owner_next;
      r_own_v     <= w_own_v_next;
      r_hcnt      <= w_hcnt_next;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;

endmodule
